pol_rd_sched: RTL and testbench
===============================

# pol_rd_sched

Round-robin read scheduler that shares the single GLB activation-read port among `POOL_CORE` pooling cores. It grants address requests fairly, enforces a per-core outstanding-read limit and a global in-flight limit, and issues the granted addresses to GLB through one registered slot. It tracks the issuing core of every in-flight read in a tag FIFO and steers each returning GLB output-feature-map word to that core in issue order.

## Interface
- `POOL_CORE`, 6: number of requesting pooling cores.
- `POOL_COMP_CORE`, 64: activations per returned word.
- `IDX_WIDTH`, 10: GLB address width.
- `ACT_WIDTH`, 8: activation width.
- `MAX_OUTS`, 2: maximum reads outstanding per core.
- `TAG_DEPTH`, 4: maximum reads in flight in total, counting the slot plus issued-but-unreturned reads.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `POLSCH_AddrVld` input `POOL_CORE`: per-core address request valid.
- `POLSCH_Addr` input `IDX_WIDTH*POOL_CORE`: per-core addresses; core i occupies `[i*IDX_WIDTH +: IDX_WIDTH]`.
- `SCHPOL_AddrRdy` output `POOL_CORE`: grant, one-hot or zero.
- `SCHGLB_AddrVld` output 1: issued address valid.
- `SCHGLB_Addr` output `IDX_WIDTH`: issued address.
- `GLBSCH_AddrRdy` input 1: GLB accepts the address.
- `GLBSCH_Ofm` input `ACT_WIDTH*POOL_COMP_CORE`: returned data.
- `GLBSCH_OfmVld` input 1: returned data valid.
- `SCHGLB_OfmRdy` output 1: scheduler accepts the returned data.
- `SCHPOL_Ofm` output `ACT_WIDTH*POOL_COMP_CORE`: data broadcast to all cores.
- `SCHPOL_OfmVld` output `POOL_CORE`: one-hot data valid for the destination core.
- `POLSCH_OfmRdy` input `POOL_CORE`: per-core data ready.
- `SCHPOL_Idle` output 1: high when no read is in the slot or in flight.

## Operation
- **State**
  - `slot_vld` and `slot_port`/`slot_addr`: the issue register.
  - `credit[i]`: 0..`MAX_OUTS` per core.
  - Tag FIFO: `TAG_DEPTH` entries of `$clog2(POOL_CORE)` bits.
  - `inflight`: 0..`TAG_DEPTH`; counts the slot plus FIFO entries.
  - `rr_ptr`: index of the last granted core.
- **Eligibility.** Core i is eligible when `POLSCH_AddrVld[i]` is high, `credit[i] < MAX_OUTS`, and `inflight < TAG_DEPTH`.
- **Grant condition.** A grant may occur only when `!slot_vld | GLBSCH_AddrRdy`, i.e. the slot is empty or is emptying this cycle.
- **Arbitration.** Combinational round-robin: the first eligible core searching from `rr_ptr+1` upward, wrapping modulo `POOL_CORE`. `SCHPOL_AddrRdy` is that one-hot grant.
- **On grant to core g**
  - Load the slot with {g, addr_g} and set `slot_vld`.
  - `credit[g]` +1.
  - `rr_ptr` <= g.
- **Issue.** `SCHGLB_AddrVld = slot_vld`. On `SCHGLB_AddrVld & GLBSCH_AddrRdy`, push `slot_port` into the tag FIFO. The slot clears unless it is reloaded by a grant in the same cycle.
- **Return path (combinational, zero latency)**
  - `SCHPOL_Ofm = GLBSCH_Ofm`.
  - `SCHPOL_OfmVld[h] = GLBSCH_OfmVld & !tag_empty`, where h is the tag FIFO head; all other bits are 0.
  - `SCHGLB_OfmRdy = !tag_empty & POLSCH_OfmRdy[h]`.
  - On transfer: pop the tag, `credit[h]` -1, `inflight` -1.
- **Counter arithmetic**
  - `inflight` +1 on grant, -1 on return transfer; a simultaneous grant and return leaves it unchanged.
  - `credit[i]` follows the same rule for its own core. A grant and return hitting the same core in the same cycle leaves its credit unchanged.
- **Boundaries**
  - `inflight == TAG_DEPTH` or `credit == MAX_OUTS` blocks grants. No same-cycle reuse of a slot freed by a return.
  - The tag FIFO cannot overflow, because `inflight` bounds it.
  - GLB data arriving with the tag FIFO empty is a protocol violation: `SCHGLB_OfmRdy` stays 0 and the data is not consumed.
  - An address request may drop before it is granted; no state changes.
- `SCHPOL_Idle = (inflight == 0)`.

## Timing
- **While `rst` is high**, and after the edge on which it is sampled:
  - `slot_vld = 0`, all credits 0, tag FIFO empty, `inflight = 0`, `rr_ptr = POOL_CORE-1`, so core 0 wins first.
  - All outputs are forced low while `rst` is high: `SCHPOL_AddrRdy`, `SCHGLB_AddrVld`, `SCHGLB_Addr`, `SCHGLB_OfmRdy`, `SCHPOL_OfmVld`, `SCHPOL_Ofm`, `SCHPOL_Idle`.
  - Reset mid-operation discards all in-flight tracking. GLB is reset by the same `rst`.
- **Latency**
  - Grant at cycle N gives `SCHGLB_AddrVld` at N+1.
  - GLB return gives core valid in the same cycle.
- **Throughput.** One grant and one issue per cycle are sustained while `GLBSCH_AddrRdy` is high and limits allow.
- **Ordering.** Returns must come back in issue order; the scheduler relies on this for steering.
- **Stability.** Once `SCHGLB_AddrVld` is high, `SCHGLB_Addr` holds until accepted.

## Test plan
- **Fair rotation.** Cores 0, 2 and 5 request continuously; GLB is always ready and returns each read after 3 cycles. Required grant sequence: 0, 2, 5, 0, 2, 5. Each core receives exactly its own data words, in order.
- **Per-core credit.** Only core 1 requests; GLB accepts addresses but withholds data. Exactly 2 grants occur, then `SCHPOL_AddrRdy[1]` stays 0. One return re-enables a grant on the following cycle.
- **Global limit.** All 6 cores request and GLB withholds data. Exactly 4 grants occur, to cores 0, 1, 2, 3, and `SCHPOL_Idle` is 0. Returns then route to 0, 1, 2, 3 in that order.
- **Backpressure.** `GLBSCH_AddrRdy` is low for 5 cycles with the slot loaded at address 0x2A. `SCHGLB_Addr` holds 0x2A, no further grant occurs, and `inflight` is 1.
- **Destination stall.** The head tag is core 3 and `POLSCH_OfmRdy[3]` is 0 while GLB data is valid. `SCHGLB_OfmRdy` is 0 and there is no pop. Raising the ready completes the transfer in the same cycle.
- **Reset mid-flight.** Assert `rst` with 3 reads in flight. The next cycle shows all outputs 0 and `inflight` 0, and core 0 is granted first after release.

Source files
------------

// File: rtl/pol_rd_sched.sv
// Round-robin scheduler sharing the GLB activation-read port among pooling cores.
// Tracks the issuing core of each in-flight read in a tag FIFO to steer returns.
module pol_rd_sched #(
  parameter int POOL_CORE      = 6,
  parameter int POOL_COMP_CORE = 64,
  parameter int IDX_WIDTH      = 10,
  parameter int ACT_WIDTH      = 8,
  parameter int MAX_OUTS       = 2,
  parameter int TAG_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [POOL_CORE-1:0]                POLSCH_AddrVld,
  input  logic [IDX_WIDTH*POOL_CORE-1:0]      POLSCH_Addr,
  output logic [POOL_CORE-1:0]                SCHPOL_AddrRdy,
  output logic                                SCHGLB_AddrVld,
  output logic [IDX_WIDTH-1:0]                SCHGLB_Addr,
  input  logic                                GLBSCH_AddrRdy,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] GLBSCH_Ofm,
  input  logic                                GLBSCH_OfmVld,
  output logic                                SCHGLB_OfmRdy,
  output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] SCHPOL_Ofm,
  output logic [POOL_CORE-1:0]                SCHPOL_OfmVld,
  input  logic [POOL_CORE-1:0]                POLSCH_OfmRdy,
  output logic                                SCHPOL_Idle
);

  localparam int PORT_W = (POOL_CORE > 1) ? $clog2(POOL_CORE) : 1;
  localparam int CRD_W  = $clog2(MAX_OUTS + 1);
  localparam int INF_W  = $clog2(TAG_DEPTH + 1);
  localparam int TPTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  logic                 slot_vld_q, slot_vld_d;
  logic [PORT_W-1:0]    slot_port_q, slot_port_d;
  logic [IDX_WIDTH-1:0] slot_addr_q, slot_addr_d;
  logic [CRD_W-1:0]     credit_q [POOL_CORE];
  logic [CRD_W-1:0]     credit_d [POOL_CORE];
  logic [INF_W-1:0]     inflight_q, inflight_d;
  logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]    tag_mem_q [TAG_DEPTH];
  logic [TPTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [TPTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [INF_W-1:0]     tag_cnt_q, tag_cnt_d;

  logic                 slot_free;
  logic [POOL_CORE-1:0] elig;
  logic [POOL_CORE-1:0] grant_oh;
  logic                 grant_vld;
  logic [PORT_W-1:0]    grant_idx;
  logic                 push;
  logic                 pop;
  logic                 tag_empty;
  logic [PORT_W-1:0]    head;
  logic [POOL_CORE-1:0] ofm_vld_oh;

  function automatic logic [TPTR_W-1:0] ptr_inc(input logic [TPTR_W-1:0] p);
    if (p == TPTR_W'(TAG_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign slot_free = !slot_vld_q || GLBSCH_AddrRdy;
  assign push      = slot_vld_q && GLBSCH_AddrRdy;
  assign tag_empty = (tag_cnt_q == '0);
  assign head      = tag_mem_q[rd_ptr_q];
  assign pop       = GLBSCH_OfmVld && !tag_empty && POLSCH_OfmRdy[head];

  // Round-robin arbitration: first eligible core after the last winner
  always_comb begin
    int idx;
    idx       = 0;
    elig      = '0;
    grant_oh  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < POOL_CORE; i++) begin
      elig[i] = POLSCH_AddrVld[i] && (credit_q[i] < CRD_W'(MAX_OUTS)) &&
                (inflight_q < INF_W'(TAG_DEPTH)) && slot_free;
    end
    for (int k = 1; k <= POOL_CORE; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= POOL_CORE) idx = idx - POOL_CORE;
      if (!grant_vld && elig[idx]) begin
        grant_vld     = 1'b1;
        grant_idx     = PORT_W'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_port_d = slot_port_q;
    slot_addr_d = slot_addr_q;
    rr_ptr_d    = rr_ptr_q;
    inflight_d  = inflight_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_cnt_d   = tag_cnt_q;
    for (int i = 0; i < POOL_CORE; i++) credit_d[i] = credit_q[i];

    if (push) slot_vld_d = 1'b0;
    if (grant_vld) begin
      slot_vld_d  = 1'b1;
      slot_port_d = grant_idx;
      slot_addr_d = POLSCH_Addr[int'(grant_idx)*IDX_WIDTH +: IDX_WIDTH];
      rr_ptr_d    = grant_idx;
    end

    if (grant_vld && !pop)      inflight_d = inflight_q + 1'b1;
    else if (pop && !grant_vld) inflight_d = inflight_q - 1'b1;

    // A grant and a return on the same core cancel out
    for (int i = 0; i < POOL_CORE; i++) begin
      if (grant_vld && grant_idx == PORT_W'(i) && !(pop && head == PORT_W'(i)))
        credit_d[i] = credit_q[i] + 1'b1;
      else if (pop && head == PORT_W'(i) && !(grant_vld && grant_idx == PORT_W'(i)))
        credit_d[i] = credit_q[i] - 1'b1;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      tag_cnt_d = tag_cnt_q + 1'b1;
    else if (pop && !push) tag_cnt_d = tag_cnt_q - 1'b1;
  end

  // Issue slot and tracking state
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q <= 1'b0;
      inflight_q <= '0;
      rr_ptr_q   <= PORT_W'(POOL_CORE - 1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_cnt_q  <= '0;
      for (int i = 0; i < POOL_CORE; i++) credit_q[i] <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      inflight_q <= inflight_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_cnt_q  <= tag_cnt_d;
      for (int i = 0; i < POOL_CORE; i++) credit_q[i] <= credit_d[i];
    end
  end

  always_ff @(posedge clk) begin
    slot_port_q <= slot_port_d;
    slot_addr_q <= slot_addr_d;
    if (push) tag_mem_q[wr_ptr_q] <= slot_port_q;
  end

  // Zero-latency return steering; every output is held low during reset
  always_comb begin
    ofm_vld_oh = '0;
    if (GLBSCH_OfmVld && !tag_empty && !rst) ofm_vld_oh[head] = 1'b1;
  end

  assign SCHPOL_AddrRdy = rst ? '0 : grant_oh;
  assign SCHGLB_AddrVld = !rst && slot_vld_q;
  assign SCHGLB_Addr    = rst ? '0 : slot_addr_q;
  assign SCHGLB_OfmRdy  = !rst && !tag_empty && POLSCH_OfmRdy[head];
  assign SCHPOL_Ofm     = rst ? '0 : GLBSCH_Ofm;
  assign SCHPOL_OfmVld  = ofm_vld_oh;
  assign SCHPOL_Idle    = !rst && (inflight_q == '0);

endmodule

// File: tb/tb_pol_rd_sched.sv
// Directed bench for pol_rd_sched: one task per scenario with inline checks.
module tb_pol_rd_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   addr_vld;
  logic [59:0]  addr;
  logic [5:0]   addr_rdy;
  logic         glb_addr_vld;
  logic [9:0]   glb_addr;
  logic         glb_addr_rdy;
  logic [511:0] glb_ofm;
  logic         glb_ofm_vld;
  logic         glb_ofm_rdy;
  logic [511:0] pol_ofm;
  logic [5:0]   ofm_vld_o;
  logic [5:0]   pol_ofm_rdy;
  logic         idle;

  int n_chk = 0;
  int n_pass = 0;

  pol_rd_sched dut (
    .clk(clk), .rst(rst),
    .POLSCH_AddrVld(addr_vld), .POLSCH_Addr(addr), .SCHPOL_AddrRdy(addr_rdy),
    .SCHGLB_AddrVld(glb_addr_vld), .SCHGLB_Addr(glb_addr), .GLBSCH_AddrRdy(glb_addr_rdy),
    .GLBSCH_Ofm(glb_ofm), .GLBSCH_OfmVld(glb_ofm_vld), .SCHGLB_OfmRdy(glb_ofm_rdy),
    .SCHPOL_Ofm(pol_ofm), .SCHPOL_OfmVld(ofm_vld_o), .POLSCH_OfmRdy(pol_ofm_rdy),
    .SCHPOL_Idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic logic [511:0] mkw(input logic [9:0] a);
    return {16{22'h2AB0F, a}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    addr_vld = '0; addr = '0; glb_addr_rdy = 1'b0;
    glb_ofm = '0; glb_ofm_vld = 1'b0; pol_ofm_rdy = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    addr_vld = '1; addr = '1; glb_addr_rdy = 1'b1;
    glb_ofm = mkw(10'h155); glb_ofm_vld = 1'b1; pol_ofm_rdy = '1;
    settle();
    n_chk++; if (addr_rdy !== 6'b0) $display("FAIL rst_addr_rdy: got %h want 00", addr_rdy); else n_pass++;
    n_chk++; if (pol_ofm !== 512'b0) $display("FAIL rst_ofm: got nonzero want 0"); else n_pass++;
    n_chk++; if (ofm_vld_o !== 6'b0) $display("FAIL rst_ofm_vld: got %h want 00", ofm_vld_o); else n_pass++;
    n_chk++; if (idle !== 1'b0) $display("FAIL rst_idle: got %b want 0", idle); else n_pass++;
    tick(); tick();
    n_chk++; if (glb_addr_vld !== 1'b0) $display("FAIL rst_glb_vld: got %b want 0", glb_addr_vld); else n_pass++;
    n_chk++; if (glb_addr !== 10'h0) $display("FAIL rst_glb_addr: got %h want 000", glb_addr); else n_pass++;
    n_chk++; if (glb_ofm_rdy !== 1'b0) $display("FAIL rst_ofm_rdy: got %b want 0", glb_ofm_rdy); else n_pass++;
    clear_inputs();
    rst = 1'b0;
    settle();
    n_chk++; if (idle !== 1'b1) $display("FAIL rst_release_idle: got %b want 1", idle); else n_pass++;
    addr_vld = '1;
    settle();
    n_chk++; if (addr_rdy !== 6'b000001) $display("FAIL rst_first_grant: got %b want 000001", addr_rdy); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_fair_rotation;
    int gcnt [6];
    int rcnt [6];
    int grants [$];
    logic [9:0] q_addr [$];
    int q_time [$];
    int exp_g [6];
    int c;
    exp_g = '{0, 2, 5, 0, 2, 5};
    for (int i = 0; i < 6; i++) begin gcnt[i] = 0; rcnt[i] = 0; end
    do_reset();
    glb_addr_rdy = 1'b1;
    pol_ofm_rdy = '1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      addr_vld = (grants.size() < 6) ? 6'b100101 : 6'b0;
      for (int i = 0; i < 6; i++) addr[i*10 +: 10] = 10'(i*16 + gcnt[i]);
      if (q_addr.size() > 0 && cyc >= q_time[0] + 3) begin
        glb_ofm_vld = 1'b1; glb_ofm = mkw(q_addr[0]);
      end else begin
        glb_ofm_vld = 1'b0; glb_ofm = '0;
      end
      settle();
      if (glb_ofm_vld && glb_ofm_rdy) begin
        c = int'(q_addr[0] >> 4);
        n_chk++; if (ofm_vld_o !== 6'(1 << c)) $display("FAIL fair_steer: got %b want core %0d", ofm_vld_o, c); else n_pass++;
        n_chk++; if (pol_ofm !== mkw(10'(c*16 + rcnt[c]))) $display("FAIL fair_data: core %0d got %h want word %0d", c, pol_ofm[9:0], rcnt[c]); else n_pass++;
        rcnt[c]++;
        void'(q_addr.pop_front());
        void'(q_time.pop_front());
      end
      for (int i = 0; i < 6; i++) if (addr_rdy[i]) begin grants.push_back(i); gcnt[i]++; end
      if (glb_addr_vld && glb_addr_rdy) begin q_addr.push_back(glb_addr); q_time.push_back(cyc); end
      tick();
    end
    n_chk++; if (grants.size() != 6) $display("FAIL fair_grant_count: got %0d want 6", grants.size()); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_chk++;
      if (k >= grants.size()) $display("FAIL fair_grant_seq[%0d]: got none want %0d", k, exp_g[k]);
      else if (grants[k] != exp_g[k]) $display("FAIL fair_grant_seq[%0d]: got %0d want %0d", k, grants[k], exp_g[k]);
      else n_pass++;
    end
    n_chk++; if (rcnt[0] != 2 || rcnt[2] != 2 || rcnt[5] != 2) $display("FAIL fair_returns: got %0d/%0d/%0d want 2/2/2", rcnt[0], rcnt[2], rcnt[5]); else n_pass++;
    n_chk++; if (idle !== 1'b1) $display("FAIL fair_idle: got %b want 1", idle); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_credit;
    int ng;
    ng = 0;
    do_reset();
    glb_addr_rdy = 1'b1;
    addr_vld = 6'b000010;
    addr[10 +: 10] = 10'h111;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (addr_rdy == 6'b000010) ng++;
      if (k == 1) begin
        n_chk++; if (glb_addr_vld !== 1'b1 || glb_addr !== 10'h111) $display("FAIL credit_issue: got %b/%h want 1/111", glb_addr_vld, glb_addr); else n_pass++;
      end
      tick();
    end
    settle();
    n_chk++; if (ng != 2) $display("FAIL credit_grants: got %0d want 2", ng); else n_pass++;
    n_chk++; if (addr_rdy !== 6'b0) $display("FAIL credit_blocked: got %b want 000000", addr_rdy); else n_pass++;
    glb_ofm_vld = 1'b1; pol_ofm_rdy = 6'b000010;
    settle();
    n_chk++; if (ofm_vld_o !== 6'b000010) $display("FAIL credit_ret_vld: got %b want 000010", ofm_vld_o); else n_pass++;
    n_chk++; if (glb_ofm_rdy !== 1'b1) $display("FAIL credit_ret_rdy: got %b want 1", glb_ofm_rdy); else n_pass++;
    n_chk++; if (addr_rdy !== 6'b0) $display("FAIL credit_same_cycle: got %b want 000000", addr_rdy); else n_pass++;
    tick();
    glb_ofm_vld = 1'b0;
    settle();
    n_chk++; if (addr_rdy !== 6'b000010) $display("FAIL credit_regrant: got %b want 000010", addr_rdy); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_global_limit;
    int grants [$];
    do_reset();
    glb_addr_rdy = 1'b1;
    addr_vld = '1;
    for (int i = 0; i < 6; i++) addr[i*10 +: 10] = 10'(8'h40 + i);
    for (int k = 0; k < 8; k++) begin
      settle();
      for (int i = 0; i < 6; i++) if (addr_rdy[i]) grants.push_back(i);
      tick();
    end
    n_chk++; if (grants.size() != 4) $display("FAIL global_count: got %0d want 4", grants.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (k >= grants.size()) $display("FAIL global_seq[%0d]: got none want %0d", k, k);
      else if (grants[k] != k) $display("FAIL global_seq[%0d]: got %0d want %0d", k, grants[k], k);
      else n_pass++;
    end
    addr_vld = '0;
    settle();
    n_chk++; if (idle !== 1'b0) $display("FAIL global_idle: got %b want 0", idle); else n_pass++;
    glb_ofm_vld = 1'b1; pol_ofm_rdy = '1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_chk++; if (ofm_vld_o !== 6'(1 << k)) $display("FAIL global_ret[%0d]: got %b want core %0d", k, ofm_vld_o, k); else n_pass++;
      tick();
    end
    glb_ofm_vld = 1'b0;
    settle();
    n_chk++; if (idle !== 1'b1) $display("FAIL global_drained: got %b want 1", idle); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_backpressure;
    do_reset();
    glb_addr_rdy = 1'b0;
    addr_vld = 6'b010000;
    addr[40 +: 10] = 10'h02A;
    addr[0 +: 10]  = 10'h0C0;
    settle();
    n_chk++; if (addr_rdy !== 6'b010000) $display("FAIL bp_grant: got %b want 010000", addr_rdy); else n_pass++;
    tick();
    addr_vld = 6'b010001;
    addr[40 +: 10] = 10'h3FF;
    for (int k = 0; k < 5; k++) begin
      settle();
      n_chk++; if (glb_addr_vld !== 1'b1 || glb_addr !== 10'h02A) $display("FAIL bp_hold[%0d]: got %b/%h want 1/02a", k, glb_addr_vld, glb_addr); else n_pass++;
      n_chk++; if (addr_rdy !== 6'b0) $display("FAIL bp_nogrant[%0d]: got %b want 000000", k, addr_rdy); else n_pass++;
      tick();
    end
    n_chk++; if (idle !== 1'b0) $display("FAIL bp_idle: got %b want 0", idle); else n_pass++;
    glb_addr_rdy = 1'b1;
    settle();
    n_chk++; if (addr_rdy !== 6'b000001) $display("FAIL bp_release_grant: got %b want 000001", addr_rdy); else n_pass++;
    tick();
    addr_vld = '0;
    settle();
    n_chk++; if (glb_addr_vld !== 1'b1 || glb_addr !== 10'h0C0) $display("FAIL bp_next_addr: got %b/%h want 1/0c0", glb_addr_vld, glb_addr); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_dest_stall;
    do_reset();
    glb_addr_rdy = 1'b1;
    addr_vld = 6'b001000;
    addr[30 +: 10] = 10'h033;
    settle();
    n_chk++; if (addr_rdy !== 6'b001000) $display("FAIL stall_grant: got %b want 001000", addr_rdy); else n_pass++;
    tick();
    addr_vld = '0;
    settle();
    n_chk++; if (glb_addr_vld !== 1'b1 || glb_addr !== 10'h033) $display("FAIL stall_issue: got %b/%h want 1/033", glb_addr_vld, glb_addr); else n_pass++;
    tick();
    glb_ofm_vld = 1'b1; glb_ofm = mkw(10'h033); pol_ofm_rdy = 6'b110111;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_chk++; if (glb_ofm_rdy !== 1'b0) $display("FAIL stall_rdy[%0d]: got %b want 0", k, glb_ofm_rdy); else n_pass++;
      n_chk++; if (ofm_vld_o !== 6'b001000) $display("FAIL stall_vld[%0d]: got %b want 001000", k, ofm_vld_o); else n_pass++;
      tick();
    end
    pol_ofm_rdy = '1;
    settle();
    n_chk++; if (glb_ofm_rdy !== 1'b1) $display("FAIL stall_release: got %b want 1", glb_ofm_rdy); else n_pass++;
    n_chk++; if (pol_ofm !== mkw(10'h033)) $display("FAIL stall_data: got %h want 033", pol_ofm[9:0]); else n_pass++;
    tick();
    settle();
    n_chk++; if (glb_ofm_rdy !== 1'b0 || ofm_vld_o !== 6'b0) $display("FAIL stall_empty: got %b/%b want 0/000000", glb_ofm_rdy, ofm_vld_o); else n_pass++;
    n_chk++; if (idle !== 1'b1) $display("FAIL stall_idle: got %b want 1", idle); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reset_midflight;
    do_reset();
    glb_addr_rdy = 1'b1;
    addr_vld = 6'b000111;
    tick(); tick(); tick();
    addr_vld = '0;
    settle();
    n_chk++; if (idle !== 1'b0) $display("FAIL mid_busy: got %b want 0", idle); else n_pass++;
    rst = 1'b1;
    addr_vld = '1; glb_ofm_vld = 1'b1; glb_ofm = mkw(10'h2C3); pol_ofm_rdy = '1;
    settle();
    n_chk++; if (addr_rdy !== 6'b0 || glb_addr_vld !== 1'b0 || glb_addr !== 10'h0) $display("FAIL mid_rst_issue: got %b/%b/%h want 0", addr_rdy, glb_addr_vld, glb_addr); else n_pass++;
    n_chk++; if (glb_ofm_rdy !== 1'b0 || ofm_vld_o !== 6'b0 || pol_ofm !== 512'b0) $display("FAIL mid_rst_ret: got %b/%b want 0/000000", glb_ofm_rdy, ofm_vld_o); else n_pass++;
    tick();
    settle();
    n_chk++; if (glb_addr_vld !== 1'b0 || idle !== 1'b0) $display("FAIL mid_rst_held: got %b/%b want 0/0", glb_addr_vld, idle); else n_pass++;
    rst = 1'b0;
    settle();
    n_chk++; if (idle !== 1'b1) $display("FAIL mid_inflight_cleared: got idle %b want 1", idle); else n_pass++;
    n_chk++; if (glb_ofm_rdy !== 1'b0 || ofm_vld_o !== 6'b0) $display("FAIL mid_tags_cleared: got %b/%b want 0/000000", glb_ofm_rdy, ofm_vld_o); else n_pass++;
    n_chk++; if (addr_rdy !== 6'b000001) $display("FAIL mid_first_grant: got %b want 000001", addr_rdy); else n_pass++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_fair_rotation();
    test_credit();
    test_global_limit();
    test_backpressure();
    test_dest_stall();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
